// File: rtl/poly_note_player_control.sv
`default_nettype none
// ============================================================================
//  Module   : poly_note_player_control
//  Purpose  : Multi-voice note player controller. Each voice runs its own
//             CLEAR/WAIT/DONE/LOAD machine, latches note and duration, and
//             times the note with a beat-driven counter. Global pause freezes
//             every counter.
//  Revision : 1.0  initial release
// ============================================================================
module poly_note_player_control #(
  parameter int VOICES = 2,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play_enable,
  input  logic                     pause,
  input  logic                     beat,
  input  logic [VOICES-1:0]        load_new_note,
  input  logic [VOICES*NOTE_W-1:0] new_note,
  input  logic [VOICES*DUR_W-1:0]  new_duration,
  output logic [VOICES-1:0]        load,
  output logic [VOICES-1:0]        note_done,
  output logic [VOICES*NOTE_W-1:0] note,
  output logic [VOICES-1:0]        busy,
  output logic                     all_idle
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  localparam logic [DUR_W-1:0] c_count_one = {{(DUR_W-1){1'b0}}, 1'b1};

  generate
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
      logic [1:0]        state_q, state_d;
      logic [NOTE_W-1:0] note_q,  note_d;
      logic [DUR_W-1:0]  dur_q,   dur_d;
      logic [DUR_W-1:0]  count_q, count_d;
      logic              busy_q,  busy_d;
      logic              timer_done;

      // Note has run its full length (a zero duration expires immediately).
      always_comb timer_done = busy_q && (count_q == dur_q);

      // Next-state and datapath for this voice; voices never interact.
      always_comb begin
        state_d = state_q;
        note_d  = note_q;
        dur_d   = dur_q;
        count_d = count_q;
        busy_d  = busy_q;
        case (state_q)
          ST_CLEAR: begin
            note_d  = '0;
            busy_d  = 1'b0;
            count_d = '0;
            state_d = ST_WAIT;
          end
          ST_WAIT: begin
            if (!play_enable) begin
              note_d  = '0;
              busy_d  = 1'b0;
              count_d = '0;
              state_d = ST_CLEAR;
            end else if (timer_done) begin
              // A request held in this cycle is served after DONE.
              note_d  = '0;
              busy_d  = 1'b0;
              count_d = '0;
              state_d = ST_DONE;
            end else if (load_new_note[v]) begin
              // Also covers retrigger: replaced note gets no note_done.
              note_d  = new_note[v*NOTE_W +: NOTE_W];
              dur_d   = new_duration[v*DUR_W +: DUR_W];
              count_d = '0;
              busy_d  = 1'b1;
              state_d = ST_LOAD;
            end else if (busy_q && beat && !pause) begin
              // timer_done is low here, so count < duration: no wrap.
              count_d = count_q + c_count_one;
            end
          end
          ST_DONE: state_d = ST_WAIT;
          ST_LOAD: state_d = ST_WAIT;
          default: state_d = ST_CLEAR;
        endcase
      end

      // Voice registers; reset drops any note without a note_done.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_CLEAR;
          note_q  <= '0;
          dur_q   <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          note_q  <= note_d;
          dur_q   <= dur_d;
          count_q <= count_d;
          busy_q  <= busy_d;
        end
      end

      assign load[v]                      = (state_q == ST_LOAD);
      assign note_done[v]                 = (state_q == ST_DONE);
      assign note[v*NOTE_W +: NOTE_W]     = note_q;
      assign busy[v]                      = busy_q;
    end
  endgenerate

  assign all_idle = ~|busy;

endmodule
`default_nettype wire

// File: tb/tb_poly_note_player_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_note_player_control
//  Purpose  : Directed self-checking bench for poly_note_player_control
//             (VOICES=2, NOTE_W=6, DUR_W=6).
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_note_player_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        pause;
  logic        beat;
  logic [1:0]  load_new_note;
  logic [11:0] new_note;
  logic [11:0] new_duration;
  logic [1:0]  load;
  logic [1:0]  note_done;
  logic [11:0] note;
  logic [1:0]  busy;
  logic        all_idle;

  int n_checks = 0;
  int n_fail   = 0;

  poly_note_player_control #(
    .VOICES(2),
    .NOTE_W(6),
    .DUR_W (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_enable  (play_enable),
    .pause        (pause),
    .beat         (beat),
    .load_new_note(load_new_note),
    .new_note     (new_note),
    .new_duration (new_duration),
    .load         (load),
    .note_done    (note_done),
    .note         (note),
    .busy         (busy),
    .all_idle     (all_idle)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic set_voice(input int v, input logic [5:0] n, input logic [5:0] d);
    new_note[v*6 +: 6]     = n;
    new_duration[v*6 +: 6] = d;
  endtask

  // Request voice(s), step into LOAD, drop request, step back to WAIT.
  task automatic start_notes(input logic [1:0] mask, input string tag);
    load_new_note = mask;
    tick();
    check_eq({tag, "_load"}, 32'(load), 32'(mask));
    load_new_note = 2'b00;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; play_enable = 1'b1; pause = 1'b0; beat = 1'b0;
    load_new_note = 2'b00; new_note = '0; new_duration = '0;
    #1;
    check_eq("rst_init_note", 32'(note), 32'h0);
    check_eq("rst_init_idle", 32'(all_idle), 32'h1);
    tick(); tick();
    reset = 1'b0;
    tick();                                     // CLEAR -> WAIT

    // ---------------- async reset mid-note ----------------
    set_voice(1, 6'd2, 6'd7);
    start_notes(2'b10, "pre_rst");
    check_eq("pre_rst_note", 32'(note[11:6]), 32'd2);
    #2 reset = 1'b1;                            // between edges
    #1;
    check_eq("async_rst_note", 32'(note), 32'h0);
    check_eq("async_rst_busy", 32'(busy), 32'h0);
    check_eq("async_rst_idle", 32'(all_idle), 32'h1);
    check_eq("async_rst_flags", 32'({load, note_done}), 32'h0);
    tick();
    reset = 1'b0;
    tick();                                     // CLEAR -> WAIT

    // ---------------- basic note: 5, duration 3 ----------------
    set_voice(0, 6'd5, 6'd3);
    load_new_note = 2'b01;
    tick();
    check_eq("basic_load", 32'(load), 32'h1);
    check_eq("basic_note", 32'(note[5:0]), 32'd5);
    check_eq("basic_busy", 32'(busy), 32'h1);
    load_new_note = 2'b00;
    tick();
    check_eq("basic_load_gone", 32'(load), 32'h0);
    beat_tick(); beat_tick(); beat_tick();
    check_eq("basic_note_held", 32'(note[5:0]), 32'd5);
    check_eq("basic_no_done_yet", 32'(note_done), 32'h0);
    tick();
    check_eq("basic_done", 32'(note_done), 32'h1);
    check_eq("basic_done_note", 32'(note[5:0]), 32'd0);
    check_eq("basic_done_busy", 32'(busy), 32'h0);
    tick();
    check_eq("basic_done_pulse", 32'(note_done), 32'h0);

    // ---------------- independence: dur 2 vs dur 4 ----------------
    set_voice(0, 6'd3, 6'd2);
    set_voice(1, 6'd4, 6'd4);
    start_notes(2'b11, "indep");
    beat_tick(); beat_tick();
    check_eq("indep_no_done", 32'(note_done), 32'h0);
    beat_tick();
    check_eq("indep_done0", 32'(note_done), 32'h1);
    check_eq("indep_idle_lo", 32'(all_idle), 32'h0);
    beat_tick();
    check_eq("indep_busy1", 32'(busy), 32'h2);
    check_eq("indep_idle_lo2", 32'(all_idle), 32'h0);
    tick();
    check_eq("indep_done1", 32'(note_done), 32'h2);
    check_eq("indep_idle_hi", 32'(all_idle), 32'h1);
    tick();

    // ---------------- pause ----------------
    set_voice(0, 6'd6, 6'd3);
    start_notes(2'b01, "pause");
    beat_tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) beat_tick();
    pause = 1'b0;
    tick();
    check_eq("pause_no_expiry", 32'(note_done), 32'h0);
    check_eq("pause_busy", 32'(busy), 32'h1);
    beat_tick(); beat_tick();
    tick();
    check_eq("pause_resume_done", 32'(note_done), 32'h1);
    tick();

    // ---------------- retrigger ----------------
    set_voice(0, 6'd8, 6'd2);
    start_notes(2'b01, "retrig_a");
    beat_tick();
    set_voice(0, 6'd9, 6'd2);
    load_new_note = 2'b01;
    tick();
    check_eq("retrig_load", 32'(load), 32'h1);
    check_eq("retrig_note", 32'(note[5:0]), 32'd9);
    load_new_note = 2'b00;
    tick();
    beat_tick();
    tick();
    check_eq("retrig_count_restart", 32'(note_done), 32'h0);
    check_eq("retrig_still_busy", 32'(busy), 32'h1);
    beat_tick();
    tick();
    check_eq("retrig_done", 32'(note_done), 32'h1);
    tick();

    // ---------------- collision with timer_done ----------------
    set_voice(0, 6'd10, 6'd1);
    start_notes(2'b01, "coll_a");
    beat_tick();                                // timer_done now high
    set_voice(0, 6'd11, 6'd2);
    load_new_note = 2'b01;
    tick();
    check_eq("coll_done_first", 32'({load, note_done}), 32'h1);
    tick();
    check_eq("coll_gap", 32'({load, note_done}), 32'h0);
    tick();
    check_eq("coll_load", 32'(load), 32'h1);
    check_eq("coll_note", 32'(note[5:0]), 32'd11);
    load_new_note = 2'b00;
    tick();
    beat_tick(); beat_tick();
    tick();
    check_eq("coll_second_done", 32'(note_done), 32'h1);
    tick();

    // ---------------- zero duration (timed rest, note 0 on voice1 first) ----------------
    set_voice(1, 6'd0, 6'd0);
    start_notes(2'b10, "zero");
    check_eq("zero_busy", 32'(busy), 32'h2);
    check_eq("zero_no_done_yet", 32'(note_done), 32'h0);
    tick();
    check_eq("zero_done", 32'(note_done), 32'h2);
    check_eq("zero_busy_clr", 32'(busy), 32'h0);
    tick();

    // ---------------- play_enable low mid-note ----------------
    set_voice(0, 6'd13, 6'd5);
    start_notes(2'b01, "dis");
    beat_tick();
    play_enable = 1'b0;
    tick();
    check_eq("dis_note", 32'(note[5:0]), 32'd0);
    check_eq("dis_busy", 32'(busy), 32'h0);
    check_eq("dis_no_done", 32'(note_done), 32'h0);
    set_voice(0, 6'd14, 6'd1);
    load_new_note = 2'b01;
    begin
      logic [1:0] seen;
      seen = 2'b00;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen = seen | load | note_done;
      end
      check_eq("dis_no_ack", 32'(seen), 32'h0);
    end
    play_enable = 1'b1;
    tick();
    check_eq("reen_wait", 32'(load), 32'h0);
    tick();
    check_eq("reen_load", 32'(load), 32'h1);
    check_eq("reen_note", 32'(note[5:0]), 32'd14);
    load_new_note = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
